// File: rtl/dh_pkg.sv
// Shared types and defaults for the Duck Hunt round sequencer.
package dh_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INTRO,
      LAUNCH,
      FLIGHT,
      RESULT,
      ROUND_END,
      GAME_OVER
   } round_state_t;

   localparam int FRAME_CNT_W = 9;

   localparam int DEF_DUCKS_PER_ROUND = 10;
   localparam int DEF_PASS_HITS       = 6;
   localparam int DEF_ROUNDS          = 5;
   localparam int DEF_SHOTS_PER_DUCK  = 3;
   localparam int DEF_INTRO_FRAMES    = 120;
   localparam int DEF_FLIGHT_FRAMES   = 300;
   localparam int DEF_RESULT_FRAMES   = 60;

   // Increment that sticks at lim instead of wrapping.
   function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic [3:0] lim);
      return (v >= lim) ? v : v + 4'd1;
   endfunction

endpackage

// File: rtl/frame_timer.sv
// Frame down-counter shared by all timed states of the round sequencer.
// load has priority over tick; expired is high while the count sits at zero.
module frame_timer
   import dh_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load,
   input  logic [FRAME_CNT_W-1:0] load_val,
   input  logic                   tick,
   output logic                   expired
);

   logic [FRAME_CNT_W-1:0] cnt_q;
   logic [FRAME_CNT_W-1:0] cnt_d;

   // Next count: reload on state entry, otherwise count frames down to zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (tick && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign expired = (cnt_q == '0);

endmodule

// File: rtl/ctl_round.sv
// Duck Hunt game-round sequencer: launches ducks, bounds their flight, counts
// shots and hits, and ends rounds. All outputs are registered.
//
//  state     | meaning
//  ----------+----------------------------------------------------------
//  IDLE      | waiting for start; overlay shown
//  INTRO     | round intro screen, timed by INTRO_FRAMES
//  LAUNCH    | one cycle: request a new duck, clear shot counter
//  FLIGHT    | duck in the air; hit, shots or timeout end it
//  RESULT    | gap after a duck's outcome, timed by RESULT_FRAMES
//  ROUND_END | one cycle: judge the round
//  GAME_OVER | counters frozen, looser shows outcome; start returns to IDLE
module ctl_round
   import dh_pkg::*;
#(
   parameter int DUCKS_PER_ROUND = DEF_DUCKS_PER_ROUND,
   parameter int PASS_HITS       = DEF_PASS_HITS,
   parameter int ROUNDS          = DEF_ROUNDS,
   parameter int SHOTS_PER_DUCK  = DEF_SHOTS_PER_DUCK,
   parameter int INTRO_FRAMES    = DEF_INTRO_FRAMES,
   parameter int FLIGHT_FRAMES   = DEF_FLIGHT_FRAMES,
   parameter int RESULT_FRAMES   = DEF_RESULT_FRAMES
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       new_frame,
   input  logic       start,
   input  logic       pause_sw,
   input  logic       hit,
   input  logic       shot_fired,
   output logic       duck_launch,
   output logic       duck_abort,
   output logic       ammo_reload,
   output logic       overlay_pause,
   output logic       looser,
   output logic [3:0] round_num,
   output logic [3:0] duck_idx,
   output logic [3:0] ducks_hit
);

   round_state_t state_q, state_d;
   logic [3:0]   shot_q, shot_d;
   logic [3:0]   duck_idx_q, duck_idx_d;
   logic [3:0]   round_q, round_d;
   logic [3:0]   hits_q, hits_d;
   logic         looser_q, looser_d;
   logic         overlay_q, overlay_d;
   logic         launch_q, launch_d;
   logic         abort_q, abort_d;
   logic         reload_q, reload_d;

   logic                   timer_load;
   logic [FRAME_CNT_W-1:0] timer_val;
   logic                   timer_expired;

   frame_timer u_frame_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (timer_load),
      .load_val (timer_val),
      .tick     (new_frame & ~pause_sw),
      .expired  (timer_expired)
   );

   // Sequencing: one transition per cycle, everything frozen while paused.
   always_comb begin
      state_d    = state_q;
      shot_d     = shot_q;
      duck_idx_d = duck_idx_q;
      round_d    = round_q;
      hits_d     = hits_q;
      looser_d   = looser_q;
      launch_d   = 1'b0;
      abort_d    = 1'b0;
      reload_d   = 1'b0;
      if (!pause_sw) begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_d    = INTRO;
                  duck_idx_d = 4'd0;
                  hits_d     = 4'd0;
                  round_d    = 4'd1;
                  reload_d   = 1'b1;
               end
            end
            INTRO: begin
               if (timer_expired) state_d = LAUNCH;
            end
            LAUNCH: begin
               launch_d = 1'b1;
               shot_d   = 4'd0;
               state_d  = FLIGHT;
            end
            FLIGHT: begin
               // hit outranks a same-cycle shot, which outranks the timeout
               if (hit) begin
                  hits_d  = sat_inc4(hits_q, 4'(DUCKS_PER_ROUND));
                  state_d = RESULT;
               end else if (shot_fired) begin
                  shot_d = shot_q + 4'd1;
                  if ((shot_q + 4'd1) >= 4'(SHOTS_PER_DUCK)) begin
                     abort_d = 1'b1;
                     state_d = RESULT;
                  end
               end else if (timer_expired) begin
                  abort_d = 1'b1;
                  state_d = RESULT;
               end
            end
            RESULT: begin
               if (timer_expired) begin
                  if (duck_idx_q < 4'(DUCKS_PER_ROUND - 1)) begin
                     duck_idx_d = duck_idx_q + 4'd1;
                     reload_d   = 1'b1;
                     state_d    = LAUNCH;
                  end else begin
                     state_d = ROUND_END;
                  end
               end
            end
            ROUND_END: begin
               if (hits_q < 4'(PASS_HITS)) begin
                  looser_d = 1'b1;
                  state_d  = GAME_OVER;
               end else if (round_q == 4'(ROUNDS)) begin
                  looser_d = 1'b0;
                  state_d  = GAME_OVER;
               end else begin
                  round_d    = round_q + 4'd1;
                  duck_idx_d = 4'd0;
                  hits_d     = 4'd0;
                  reload_d   = 1'b1;
                  state_d    = INTRO;
               end
            end
            GAME_OVER: begin
               if (start) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
      if (state_d != GAME_OVER) looser_d = 1'b0;
      overlay_d = pause_sw | (state_d inside {IDLE, INTRO});
   end

   // Timer reload on entry to any timed state, with that state's duration.
   always_comb begin
      timer_load = (state_d != state_q) && (state_d inside {INTRO, FLIGHT, RESULT});
      case (state_d)
         INTRO:   timer_val = FRAME_CNT_W'(INTRO_FRAMES);
         FLIGHT:  timer_val = FRAME_CNT_W'(FLIGHT_FRAMES);
         RESULT:  timer_val = FRAME_CNT_W'(RESULT_FRAMES);
         default: timer_val = '0;
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         shot_q     <= 4'd0;
         duck_idx_q <= 4'd0;
         round_q    <= 4'd1;
         hits_q     <= 4'd0;
         looser_q   <= 1'b0;
         overlay_q  <= 1'b1;
         launch_q   <= 1'b0;
         abort_q    <= 1'b0;
         reload_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         shot_q     <= shot_d;
         duck_idx_q <= duck_idx_d;
         round_q    <= round_d;
         hits_q     <= hits_d;
         looser_q   <= looser_d;
         overlay_q  <= overlay_d;
         launch_q   <= launch_d;
         abort_q    <= abort_d;
         reload_q   <= reload_d;
      end
   end

   assign duck_launch   = launch_q;
   assign duck_abort    = abort_q;
   assign ammo_reload   = reload_q;
   assign overlay_pause = overlay_q;
   assign looser        = looser_q;
   assign round_num     = round_q;
   assign duck_idx      = duck_idx_q;
   assign ducks_hit     = hits_q;

endmodule
